serial_adder: RTL

- Parametrised multi-cycle adder/subtractor: one DIGIT-bit slice of two WIDTH-bit operands per clock, with the carry held in a register between cycles.
- Valid/ready handshake on input and output.
- Supports add and subtract modes, carry/borrow chaining and a signed-overflow flag.
- Sits beside the combinational adder cells as the area-lean option for wide datapaths.

---
 rtl/serial_adder_pkg.sv | 24 ++
 rtl/serial_adder_slice.sv | 29 ++
 rtl/serial_adder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder: FSM encoding and step/counter sizing.
package serial_adder_pkg;

  // Operation phases: waiting for operands, stepping digits, presenting result.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Number of digit steps needed to cover a full operand.
  function automatic int step_count(input int width, input int digit);
    return width / digit;
  endfunction

  // Step counter width; one spare bit so the last index never aliases zero.
  function automatic int cnt_width(input int width, input int digit);
    return $clog2(width / digit) + 1;
  endfunction

  // Counter width for the default 8-bit, bit-serial configuration.
  localparam int DEFAULT_CNT_W = cnt_width(8, 1);

endpackage

// File: rtl/serial_adder_slice.sv
// Combinational DIGIT-bit ripple adder used once per clock by serial_adder.
// c_msb is the carry into the top bit, needed for signed overflow.
module adder_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic w_carry;

  // Ripple the carry through the digit, remembering the carry into the top bit.
  always_comb begin
    s       = '0;
    c_msb   = 1'b0;
    w_carry = ci;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]    = x[i] ^ y[i] ^ w_carry;
      c_msb   = w_carry;
      w_carry = (x[i] & y[i]) | (w_carry & (x[i] ^ y[i]));
    end
    co = w_carry;
  end

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: one DIGIT-bit slice per clock, carry held in a
// register between steps. Handshake: a transfer happens on a rising edge where
// valid and ready are both high; in_ready and out_valid are never high together.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
    $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
  end

  localparam int            STEPS = step_count(WIDTH, DIGIT);
  localparam int            CW    = cnt_width(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST  = CW'(STEPS - 1);

  state_t           r_state;
  state_t           w_next;
  logic             w_capture;
  logic             w_last;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_sub;
  logic             r_cout;
  logic             r_ovf;
  logic [DIGIT-1:0] w_s;
  logic             w_co;
  logic             w_cmsb;

  // Operands shift right each step, so the current digit is always at the bottom.
  adder_slice #(.DIGIT(DIGIT)) u_slice (
    .x     (r_a[DIGIT-1:0]),
    .y     (r_b[DIGIT-1:0]),
    .ci    (r_carry),
    .s     (w_s),
    .co    (w_co),
    .c_msb (w_cmsb)
  );

  // Next-state and handshake outputs; in_ready is held low while rst is high.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w_capture = 1'b0;
    w_last    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) begin
          w_capture = 1'b1;
          w_next    = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_cnt == LAST) begin
          w_last = 1'b1;
          w_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Datapath: capture operands (b inverted and carry adjusted for subtract),
  // then fold one digit per RUN cycle into the top of the sum shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_sub   <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_capture) begin
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub ? ~cin : cin;
      r_sub   <= sub;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_sum   <= (r_sum >> DIGIT) | (WIDTH'(w_s) << (WIDTH - DIGIT));
      r_carry <= w_co;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_cout <= w_co ^ r_sub;
        r_ovf  <= w_co ^ w_cmsb;
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule
